eda_pixel_flag_ram: RTL and testbench

Per-pixel state store and raster scan engine for the regional-maximum pipeline. It holds a 2-bit flag (FREE/QUEUED/DONE) for every pixel of an M×N frame. It accepts 8-neighbour queue marks and done writes from the flood-fill datapath. It runs a row-parallel search that offers the next FREE seed pixel over a valid/ready handshake, and it raises frame_done once no FREE pixel remains.

---
 rtl/eda_pixel_flag_ram.sv | 213 +++++++++++++++++++++
 tb/tb_eda_pixel_flag_ram.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eda_pixel_flag_ram.sv
// Per-pixel FREE/QUEUED/DONE flag store with a row-parallel raster search for free seeds.
// Optional build macro EDA_FLAG_STRB_OUT_EN adds the one-hot strb_value output.
module eda_pixel_flag_ram #(
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int I_WIDTH    = 3,
    parameter int J_WIDTH    = 3,
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     mark_valid,
    input  logic [7:0]               mark_mask,
    input  logic [8*ADDR_WIDTH-1:0]  neigh_addr,
    input  logic                     done_valid,
    input  logic [ADDR_WIDTH-1:0]    done_addr,
    output logic                     next_valid,
    input  logic                     next_ready,
    output logic [ADDR_WIDTH-1:0]    next_addr,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [1:0]               rd_flag,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(M*N+1)-1:0] free_count
`ifdef EDA_FLAG_STRB_OUT_EN
    ,
    output logic [M-1:0][N-1:0]      strb_value
`endif
);
    localparam int CW = $clog2(M*N+1);
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] QUEUED = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_OFFER, S_FINISH} state_t;

    state_t                   state;
    logic [I_WIDTH-1:0]       row_ptr;
    logic [J_WIDTH-1:0]       col_ptr;
    logic [M-1:0][N-1:0][1:0] flags;
    logic [N-1:0][1:0]        row_flags;
    logic                     hit;
    logic [J_WIDTH-1:0]       hit_col;
    logic [CW-1:0]            free_total;
    logic                     handshake;

    // Seed handshake: next_valid is high for the whole of OFFER and next_addr is frozen
    // until the cycle where next_valid & next_ready are both high; an offer is never withdrawn.
    assign handshake = (state == S_OFFER) && next_ready;

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [1:0] flag_q;
            logic       mark_hit;
            logic       done_hit;
            logic       claim_hit;

            always_comb begin
                mark_hit = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (mark_mask[k] &&
                        neigh_addr[k*ADDR_WIDTH + J_WIDTH +: I_WIDTH] == I_WIDTH'(gi) &&
                        neigh_addr[k*ADDR_WIDTH +: J_WIDTH] == J_WIDTH'(gj))
                        mark_hit = 1'b1;
                end
            end

            assign done_hit  = done_valid &&
                               done_addr[J_WIDTH +: I_WIDTH] == I_WIDTH'(gi) &&
                               done_addr[J_WIDTH-1:0] == J_WIDTH'(gj);
            assign claim_hit = handshake &&
                               next_addr[J_WIDTH +: I_WIDTH] == I_WIDTH'(gi) &&
                               next_addr[J_WIDTH-1:0] == J_WIDTH'(gj);

            // Priority: clear, then done, then claim/mark (both only promote FREE to QUEUED).
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    flag_q <= FREE;
                else if (clear)
                    flag_q <= FREE;
                else if (done_hit)
                    flag_q <= DONE;
                else if ((claim_hit || (mark_valid && mark_hit)) && flag_q == FREE)
                    flag_q <= QUEUED;
            end

            assign flags[gi][gj] = flag_q;
        end
    end

    always_comb begin
        row_flags = '0;
        for (int i = 0; i < M; i++) begin
            if (row_ptr == I_WIDTH'(i))
                row_flags = flags[i];
        end
        hit     = 1'b0;
        hit_col = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (row_flags[j] == FREE && J_WIDTH'(j) >= col_ptr) begin
                hit     = 1'b1;
                hit_col = J_WIDTH'(j);
            end
        end
    end

    always_comb begin
        rd_flag = FREE;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rd_addr[J_WIDTH +: I_WIDTH] == I_WIDTH'(i) &&
                    rd_addr[J_WIDTH-1:0] == J_WIDTH'(j))
                    rd_flag = flags[i][j];
            end
        end
    end

    always_comb begin
        free_total = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (flags[i][j] == FREE)
                    free_total = free_total + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            row_ptr    <= '0;
            col_ptr    <= '0;
            next_valid <= 1'b0;
            next_addr  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            free_count <= CW'(M*N);
        end else begin
            free_count <= free_total;
            if (clear) begin
                state      <= S_IDLE;
                row_ptr    <= '0;
                col_ptr    <= '0;
                next_valid <= 1'b0;
                next_addr  <= '0;
                busy       <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_FINISH: begin
                        if (start) begin
                            state      <= S_SEARCH;
                            row_ptr    <= '0;
                            col_ptr    <= '0;
                            busy       <= 1'b1;
                            frame_done <= 1'b0;
                        end
                    end
                    S_SEARCH: begin
                        if (hit) begin
                            state      <= S_OFFER;
                            next_addr  <= ADDR_WIDTH'({row_ptr, hit_col});
                            next_valid <= 1'b1;
                        end else if (row_ptr == I_WIDTH'(M - 1)) begin
                            state      <= S_FINISH;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            row_ptr <= row_ptr + 1'b1;
                            col_ptr <= '0;
                        end
                    end
                    S_OFFER: begin
                        if (next_ready) begin
                            next_valid <= 1'b0;
                            if (next_addr[J_WIDTH-1:0] != J_WIDTH'(N - 1)) begin
                                state   <= S_SEARCH;
                                col_ptr <= next_addr[J_WIDTH-1:0] + 1'b1;
                            end else if (row_ptr != I_WIDTH'(M - 1)) begin
                                state   <= S_SEARCH;
                                row_ptr <= row_ptr + 1'b1;
                                col_ptr <= '0;
                            end else begin
                                state      <= S_FINISH;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef EDA_FLAG_STRB_OUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_value <= '0;
        end else if (clear || handshake) begin
            strb_value <= '0;
        end else if (state == S_SEARCH && hit) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++)
                    strb_value[i][j] <= (row_ptr == I_WIDTH'(i)) && (hit_col == J_WIDTH'(j));
            end
        end
    end
`endif

endmodule

// File: tb/tb_eda_pixel_flag_ram.sv
// Bench for eda_pixel_flag_ram: table-driven flag writes, hand-written scan corner cases,
// and randomized writes followed by scans checked against an array model of the flags.
`timescale 1ns/1ps
module tb_eda_pixel_flag_ram;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int IW = 4;
    localparam int JW = 4;
    localparam int AW = IW + JW;
    localparam int CW = $clog2(M*N+1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          mark_valid = 1'b0;
    logic [7:0]    mark_mask = '0;
    logic [8*AW-1:0] neigh_addr = '0;
    logic          done_valid = 1'b0;
    logic [AW-1:0] done_addr = '0;
    logic          next_ready = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          next_valid;
    logic [AW-1:0] next_addr;
    logic [1:0]    rd_flag;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] free_count;
`ifdef EDA_FLAG_STRB_OUT_EN
    logic [M-1:0][N-1:0] strb_value;
`endif

    eda_pixel_flag_ram #(
        .M(M), .N(N), .I_WIDTH(IW), .J_WIDTH(JW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start(start),
        .mark_valid(mark_valid), .mark_mask(mark_mask), .neigh_addr(neigh_addr),
        .done_valid(done_valid), .done_addr(done_addr),
        .next_valid(next_valid), .next_ready(next_ready), .next_addr(next_addr),
        .rd_addr(rd_addr), .rd_flag(rd_flag), .busy(busy), .frame_done(frame_done),
        .free_count(free_count)
`ifdef EDA_FLAG_STRB_OUT_EN
        , .strb_value(strb_value)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lag_free = M*N;
    logic [1:0] mflag [M][N];
    logic [AW-1:0] exp_q[$];

    typedef struct {
        logic          done_v;
        logic [AW-1:0] done_a;
        logic          mark_v;
        logic [7:0]    mask;
        logic [8*AW-1:0] neigh;
        logic [AW-1:0] rd_a;
        logic [1:0]    exp_flag;
        int            exp_free;
    } vec_t;
    vec_t vecs[11];

    function automatic logic [AW-1:0] pa(input int r, input int c);
        return AW'(r * (1 << JW) + c);
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (mflag[r][c] == 2'b00) n++;
        return n;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                mflag[r][c] = 2'b00;
    endfunction

    function automatic void model_claim(input logic [AW-1:0] a);
        int r = int'(a[AW-1:JW]);
        int c = int'(a[JW-1:0]);
        if (r < M && c < N && mflag[r][c] == 2'b00) mflag[r][c] = 2'b01;
    endfunction

    // Applies the write inputs currently driven, as seen by the next clock edge.
    function automatic void model_write();
        logic [AW-1:0] a;
        int r;
        int c;
        if (clear) begin
            model_reset();
            return;
        end
        if (mark_valid) begin
            for (int k = 0; k < 8; k++) begin
                if (mark_mask[k]) begin
                    a = neigh_addr[k*AW +: AW];
                    r = int'(a[AW-1:JW]);
                    c = int'(a[JW-1:0]);
                    if (r < M && c < N && mflag[r][c] == 2'b00) mflag[r][c] = 2'b01;
                end
            end
        end
        if (done_valid) begin
            r = int'(done_addr[AW-1:JW]);
            c = int'(done_addr[JW-1:0]);
            if (r < M && c < N) mflag[r][c] = 2'b10;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        lag_free = model_free();
        model_write();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rd_check(input string name, input int r, input int c);
        logic [1:0] e;
        rd_addr = pa(r, c);
        #1;
        e = (r < M && c < N) ? mflag[r][c] : 2'b00;
        chk(name, 32'(rd_flag), 32'(e));
    endtask

    task automatic do_done(input int r, input int c);
        done_valid = 1'b1;
        done_addr  = pa(r, c);
        cycle();
        done_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int g = 0;
        while (!next_valid && g < 40) begin
            cycle();
            g++;
        end
        if (!next_valid) begin
            total++;
            bad++;
            $display("FAIL %s: next_valid stayed 0, required 1", name);
        end
    endtask

    // Starts a scan and consumes every offer; the expected offers are all FREE pixels in raster order.
    task automatic scan_all(input string tag, input int ready_pct, input int exp_lat);
        int guard = 0;
        int start_cyc;
        int last_cyc = 0;
        bit holding = 1'b0;
        bit first = 1'b1;
        logic [AW-1:0] cur = '0;
        exp_q.delete();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                if (mflag[r][c] == 2'b00) exp_q.push_back(pa(r, c));
        start = 1'b1;
        cycle();
        start = 1'b0;
        start_cyc = cyc;
        while (!frame_done && guard < 600) begin
            guard++;
            if (next_valid) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL %s_extra_offer: got %0d required no offer", tag, next_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        chk({tag, "_offer"}, 32'(next_addr), 32'(cur));
                        if (first && exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
                        if (!first && ready_pct == 100) chk({tag, "_interval"}, 32'(cyc - last_cyc), 32'd2);
                        first = 1'b0;
                        last_cyc = cyc;
                    end
                    holding = 1'b1;
                end else begin
                    chk({tag, "_stable"}, 32'(next_addr), 32'(cur));
                end
                next_ready = ($urandom_range(99, 0) < ready_pct);
                if (next_ready) begin
                    model_claim(cur);
                    holding = 1'b0;
                end
            end else begin
                if (holding) begin
                    total++;
                    bad++;
                    $display("FAIL %s_retracted: next_valid got 0 required 1", tag);
                    holding = 1'b0;
                end
                next_ready = 1'($urandom_range(1, 0));
            end
            cycle();
        end
        next_ready = 1'b0;
        if (guard >= 600) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: frame_done got 0 required 1", tag);
        end
        chk({tag, "_left_over"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        model_reset();

        // Reset values
        #12;
        chk("rst_next_valid", 32'(next_valid), 32'd0);
        chk("rst_next_addr", 32'(next_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_free_count", 32'(free_count), 32'd64);
        #8 reset_n = 1'b1;
        cycle();

        // Table-driven flag writes and read-back
        vecs[0]  = '{1'b1, pa(3,4), 1'b1, 8'hFF,
                     {pa(2,3), pa(2,4), pa(2,5), pa(3,3), pa(3,5), pa(4,3), pa(4,4), pa(4,5)},
                     pa(3,4), 2'b10, 55};
        vecs[1]  = '{1'b0, '0, 1'b0, 8'h00, '0, pa(2,3), 2'b01, 55};
        vecs[2]  = '{1'b0, '0, 1'b0, 8'h00, '0, pa(4,5), 2'b01, 55};
        vecs[3]  = '{1'b0, '0, 1'b1, 8'h08, {32'h0, pa(9,1), 24'h0}, pa(1,1), 2'b00, 55};
        vecs[4]  = '{1'b1, pa(0,0), 1'b1, 8'h01, '0, pa(0,0), 2'b10, 54};
        vecs[5]  = '{1'b0, '0, 1'b1, 8'h01, {56'h0, pa(3,4)}, pa(3,4), 2'b10, 54};
        vecs[6]  = '{1'b1, pa(2,3), 1'b0, 8'h00, '0, pa(2,3), 2'b10, 54};
        vecs[7]  = '{1'b1, pa(2,9), 1'b0, 8'h00, '0, pa(2,1), 2'b00, 54};
        vecs[8]  = '{1'b0, '0, 1'b1, 8'h03, {48'h0, pa(5,5), pa(5,5)}, pa(5,5), 2'b01, 53};
        vecs[9]  = '{1'b0, '0, 1'b0, 8'h00, '0, pa(8,0), 2'b00, 53};
        vecs[10] = '{1'b0, '0, 1'b0, 8'h00, '0, pa(9,1), 2'b00, 53};
        for (int v = 0; v < 11; v++) begin
            done_valid = vecs[v].done_v;
            done_addr  = vecs[v].done_a;
            mark_valid = vecs[v].mark_v;
            mark_mask  = vecs[v].mask;
            neigh_addr = vecs[v].neigh;
            cycle();
            done_valid = 1'b0;
            mark_valid = 1'b0;
            cycle();
            rd_addr = vecs[v].rd_a;
            #1;
            chk($sformatf("vec%0d_rd_flag", v), 32'(rd_flag), 32'(vecs[v].exp_flag));
            chk($sformatf("vec%0d_free_count", v), 32'(free_count), 32'(vecs[v].exp_free));
        end

        // Full scan of an all-FREE frame with ready held high
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        chk("clear_free_count", 32'(free_count), 32'd64);
        scan_all("full", 100, 1);
        chk("full_frame_done", 32'(frame_done), 32'd1);
        cycle();
        chk("full_free_count", 32'(free_count), 32'd0);
        rd_check("full_flag_7_7", 7, 7);

        // Rows 0-2 DONE: first offer is (3,0) after 4 cycles
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N; c++)
                do_done(r, c);
        scan_all("skip_rows", 100, 4);

        // Offer held at (1,2) while it is marked DONE, then resumes at (1,3)
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int c = 0; c < N; c++) do_done(0, c);
        do_done(1, 0);
        do_done(1, 1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_valid("hold_first_valid");
        chk("hold_first_addr", 32'(next_addr), 32'(pa(1,2)));
        for (int t = 0; t < 5; t++) begin
            next_ready = 1'b0;
            if (t == 0) begin
                done_valid = 1'b1;
                done_addr  = pa(1,2);
            end
            cycle();
            done_valid = 1'b0;
            chk("hold_valid", 32'(next_valid), 32'd1);
            chk("hold_addr", 32'(next_addr), 32'(pa(1,2)));
        end
        rd_check("hold_flag_done", 1, 2);
        next_ready = 1'b1;
        model_claim(pa(1,2));
        cycle();
        next_ready = 1'b0;
        chk("hs_valid_drop", 32'(next_valid), 32'd0);
        chk("hs_flag_still_done", 32'(rd_flag), 32'd2);
        wait_valid("resume_valid");
        chk("resume_addr", 32'(next_addr), 32'(pa(1,3)));

        // Clear while offering (1,3)
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_next_valid", 32'(next_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        rd_check("clr_flag_1_2", 1, 2);
        rd_check("clr_flag_0_0", 0, 0);
        cycle();
        chk("clr_free_count", 32'(free_count), 32'd64);
        scan_all("after_clear", 60, 1);

        // Randomized writes then scan
        for (int it = 0; it < 3; it++) begin
            clear = 1'b1;
            cycle();
            clear = 1'b0;
            for (int n = 0; n < 40; n++) begin
                done_valid = ($urandom_range(3, 0) == 0);
                done_addr  = pa($urandom_range(9, 0), $urandom_range(9, 0));
                mark_valid = 1'($urandom_range(1, 0));
                mark_mask  = 8'($urandom);
                for (int k = 0; k < 8; k++)
                    neigh_addr[k*AW +: AW] = pa($urandom_range(9, 0), $urandom_range(9, 0));
                cycle();
                chk("rand_free_count", 32'(free_count), 32'(lag_free));
                rd_check("rand_rd_flag", $urandom_range(9, 0), $urandom_range(9, 0));
            end
            done_valid = 1'b0;
            mark_valid = 1'b0;
            cycle();
            scan_all("rand_scan", 50, -1);
            cycle();
            chk("rand_end_free_count", 32'(free_count), 32'(model_free()));
        end

        // Asynchronous reset in the middle of an offer
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_next_valid", 32'(next_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_free_count", 32'(free_count), 32'd64);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        rd_check("async_rst_flag", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
